// File: rtl/sha2_pkg.sv
// Shared SHA-224/SHA-256 constants, round helper functions and engine state enum.
package sha2_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned NUM_RND = 64;
  localparam int unsigned SCHED_N = 16;
  localparam int unsigned RND_W   = 6;

  typedef logic [WORD_W-1:0] word_t;

  // Eight 32-bit words; element 0 is H0 / working var a and sits in the MSBs.
  typedef logic [0:7][WORD_W-1:0] sha2_state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ADD   = 2'd2,
    ST_DONE  = 2'd3
  } sha2_state_e;

  localparam sha2_state_t IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam sha2_state_t IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic word_t bswap(input word_t x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // One compression round on working vars a..h.
  function automatic sha2_state_t sha2_round(input sha2_state_t s, input word_t k, input word_t w);
    word_t       t1;
    word_t       t2;
    sha2_state_t n;
    t1   = s[7] + big_sigma1(s[4]) + ch(s[4], s[5], s[6]) + k + w;
    t2   = big_sigma0(s[0]) + maj(s[0], s[1], s[2]);
    n[0] = t1 + t2;
    n[1] = s[0];
    n[2] = s[1];
    n[3] = s[2];
    n[4] = s[3] + t1;
    n[5] = s[4];
    n[6] = s[5];
    n[7] = s[6];
    return n;
  endfunction

endpackage

// File: rtl/sha2_msg_schedule.sv
// 16-word rolling message schedule: supplies W_r from the stream or the expander.
module sha2_msg_schedule
  import sha2_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  shift_en,
  input  logic  sel_ext,
  input  word_t w_ext,
  output word_t w_out
);

  // sched_q[0] holds W[r-16], sched_q[15] holds W[r-1].
  logic [0:SCHED_N-1][WORD_W-1:0] sched_q;
  word_t                          w_exp;

  // Expanded word and source select for the current round.
  always_comb begin
    w_exp = small_sigma1(sched_q[14]) + sched_q[9] + small_sigma0(sched_q[1]) + sched_q[0];
    w_out = sel_ext ? w_ext : w_exp;
  end

  // Shift the current round word in whenever the round advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched_q <= '0;
    end else if (shift_en) begin
      sched_q <= {sched_q[1:SCHED_N-1], w_out};
    end
  end

endmodule

// File: rtl/sha2_block_engine.sv
// Multi-block SHA-224/SHA-256 compression engine, one round per clock.
module sha2_block_engine
  import sha2_pkg::*;
#(
  parameter bit BYTE_SWAP = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode_224,
  input  logic         abort,
  input  logic         w_valid,
  output logic         w_ready,
  input  logic [31:0]  w_data,
  input  logic         w_last,
  output logic         busy,
  output logic         digest_valid,
  output logic [255:0] digest
);

  sha2_state_e           state_q, state_d;
  logic [RND_W-1:0]      r_q, r_d;
  sha2_state_t           h_q, h_d;
  sha2_state_t           v_q, v_d;
  logic                  last_q, last_d;
  logic                  mode_q, mode_d;
  logic                  advance;
  logic                  sel_ext;
  word_t                 w_t;
  logic                  w_ready_d;
  logic                  busy_d;
  logic                  digest_valid_d;

  sha2_msg_schedule u_sched (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (advance),
    .sel_ext  (sel_ext),
    .w_ext    (w_data),
    .w_out    (w_t)
  );

  // Next-state, datapath update and registered-output decode.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    h_d     = h_q;
    v_d     = v_q;
    last_d  = last_q;
    mode_d  = mode_q;
    advance = 1'b0;
    sel_ext = (r_q < RND_W'(SCHED_N));

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode_224;
          h_d     = mode_224 ? IV224 : IV256;
          v_d     = mode_224 ? IV224 : IV256;
          r_d     = '0;
          last_d  = 1'b0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        advance = sel_ext ? w_valid : 1'b1;
        if (advance) begin
          v_d = sha2_round(v_q, K[r_q], w_t);
          r_d = r_q + RND_W'(1);
          if (r_q == RND_W'(SCHED_N - 1)) begin
            last_d = w_last;
          end
          if (r_q == RND_W'(NUM_RND - 1)) begin
            state_d = ST_ADD;
          end
        end
      end
      ST_ADD: begin
        for (int i = 0; i < 8; i++) begin
          h_d[i] = h_q[i] + v_q[i];
        end
        v_d     = h_d;
        r_d     = '0;
        state_d = last_q ? ST_DONE : ST_ROUND;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over everything; H content is left as-is.
    if (abort) begin
      state_d = ST_IDLE;
      r_d     = '0;
    end

    w_ready_d      = (state_d == ST_ROUND) && (r_d < RND_W'(SCHED_N));
    busy_d         = (state_d != ST_IDLE);
    digest_valid_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      r_q          <= '0;
      h_q          <= IV256;
      v_q          <= IV256;
      last_q       <= 1'b0;
      mode_q       <= 1'b0;
      w_ready      <= 1'b0;
      busy         <= 1'b0;
      digest_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      h_q          <= h_d;
      v_q          <= v_d;
      last_q       <= last_d;
      mode_q       <= mode_d;
      w_ready      <= w_ready_d;
      busy         <= busy_d;
      digest_valid <= digest_valid_d;
    end
  end

  // Digest view of H with optional byte swap and SHA-224 truncation.
  always_comb begin
    sha2_state_t dig;
    for (int i = 0; i < 8; i++) begin
      dig[i] = BYTE_SWAP ? bswap(h_q[i]) : h_q[i];
    end
    if (mode_q) begin
      dig[7] = '0;
    end
    digest = dig;
  end

endmodule

// File: tb/tb_sha2_block_engine.sv
// Directed self-checking bench for sha2_block_engine (plain and byte-swapped instances).
module tb_sha2_block_engine;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         mode_224;
  logic         abort;
  logic         w_valid;
  logic [31:0]  w_data;
  logic         w_last;
  logic         w_ready, w_ready_sw;
  logic         busy, busy_sw;
  logic         digest_valid, digest_valid_sw;
  logic [255:0] digest, digest_sw;

  logic [31:0]  msg [0:31];
  int           nchk;
  int           npass;
  int           nfail;

  sha2_block_engine #(.BYTE_SWAP(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_224(mode_224), .abort(abort),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .busy(busy), .digest_valid(digest_valid), .digest(digest)
  );

  sha2_block_engine #(.BYTE_SWAP(1'b1)) dut_sw (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_224(mode_224), .abort(abort),
    .w_valid(w_valid), .w_ready(w_ready_sw), .w_data(w_data), .w_last(w_last),
    .busy(busy_sw), .digest_valid(digest_valid_sw), .digest(digest_sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_msg();
    for (int i = 0; i < 32; i++) msg[i] = 32'h0;
  endtask

  // Start a message at a negedge (cycle 0) and feed msg[0..nwords-1];
  // stops on digest_valid, abort or reset injection.
  task automatic run_msg(input bit m224, input int nwords, input bit gaps,
                         input int abort_cyc, input int rst_cyc, input int glitch_cyc,
                         output int done_cyc, output int ngap);
    int cyc;
    int idx;
    bit xfer;
    start = 1'b1;
    mode_224 = m224;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    idx = 0;
    ngap = 0;
    done_cyc = -1;
    while (cyc < 400) begin
      if (digest_valid) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == abort_cyc) begin
        abort = 1'b1;
        w_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        break;
      end
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
        w_valid = 1'b0;
        @(negedge clk);
        break;
      end
      start = (cyc == glitch_cyc);
      xfer = 1'b0;
      w_valid = 1'b0;
      w_last = 1'b0;
      w_data = $urandom;
      if (w_ready && idx < nwords) begin
        if (gaps && $urandom_range(0, 2) == 0) begin
          ngap++;
        end else begin
          w_valid = 1'b1;
          w_data = msg[idx];
          w_last = (idx == nwords - 1);
          xfer = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
      if (xfer) idx++;
    end
    start = 1'b0;
    w_valid = 1'b0;
    w_last = 1'b0;
  endtask

  localparam logic [255:0] IV256_DIG = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] IV256_SW  = 256'h67e6096a85ae67bb72f36e3c3af54fa57f520e518c68059babd9831f19cde05b;
  localparam logic [255:0] ABC256    = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ABC224    = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  localparam logic [255:0] TWO256    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] EMPTY256  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  initial begin
    int done_cyc;
    int ngap;
    bit seen;
    nchk = 0;
    npass = 0;
    nfail = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mode_224 = 1'b0;
    abort = 1'b0;
    w_valid = 1'b0;
    w_data = 32'h0;
    w_last = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_busy", 256'(busy), 256'(1'b0));
    check("rst_w_ready", 256'(w_ready), 256'(1'b0));
    check("rst_digest_valid", 256'(digest_valid), 256'(1'b0));
    check("rst_digest", digest, IV256_DIG);
    check("rst_digest_swapped", digest_sw, IV256_SW);

    // 1: "abc" SHA-256, no gaps
    clear_msg();
    msg[0] = 32'h61626380;
    msg[15] = 32'h00000018;
    run_msg(1'b0, 16, 1'b0, -1, -1, -1, done_cyc, ngap);
    check("abc256_cycle", 256'(done_cyc), 256'(66));
    check("abc256_digest", digest, ABC256);
    @(negedge clk);
    check("abc256_pulse_one_cycle", 256'(digest_valid), 256'(1'b0));
    check("abc256_idle_busy", 256'(busy), 256'(1'b0));
    repeat (3) @(negedge clk);
    check("abc256_digest_held_idle", digest, ABC256);

    // 2: "abc" SHA-224
    run_msg(1'b1, 16, 1'b0, -1, -1, -1, done_cyc, ngap);
    check("abc224_cycle", 256'(done_cyc), 256'(66));
    check("abc224_digest", digest, ABC224);
    @(negedge clk);

    // 3: two-block message
    clear_msg();
    msg[0]  = 32'h61626364; msg[1]  = 32'h62636465; msg[2]  = 32'h63646566; msg[3]  = 32'h64656667;
    msg[4]  = 32'h65666768; msg[5]  = 32'h66676869; msg[6]  = 32'h6768696a; msg[7]  = 32'h68696a6b;
    msg[8]  = 32'h696a6b6c; msg[9]  = 32'h6a6b6c6d; msg[10] = 32'h6b6c6d6e; msg[11] = 32'h6c6d6e6f;
    msg[12] = 32'h6d6e6f70; msg[13] = 32'h6e6f7071; msg[14] = 32'h80000000; msg[15] = 32'h00000000;
    msg[31] = 32'h000001c0;
    run_msg(1'b0, 32, 1'b0, -1, -1, -1, done_cyc, ngap);
    check("two_block_cycle", 256'(done_cyc), 256'(131));
    check("two_block_digest", digest, TWO256);
    @(negedge clk);

    // 4: empty message with random w_valid gaps
    clear_msg();
    msg[0] = 32'h80000000;
    run_msg(1'b0, 16, 1'b1, -1, -1, -1, done_cyc, ngap);
    check("empty_gaps_cycle", 256'(done_cyc), 256'(66 + ngap));
    check("empty_gaps_digest", digest, EMPTY256);
    @(negedge clk);

    // 5: abort at r=30, then "abc" with a start pulse while busy
    clear_msg();
    msg[0] = 32'h61626380;
    msg[15] = 32'h00000018;
    run_msg(1'b0, 16, 1'b0, 31, -1, -1, done_cyc, ngap);
    check("abort_busy_clear", 256'(busy), 256'(1'b0));
    check("abort_w_ready_clear", 256'(w_ready), 256'(1'b0));
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (digest_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_digest_valid", 256'(seen), 256'(1'b0));
    run_msg(1'b0, 16, 1'b0, -1, -1, 10, done_cyc, ngap);
    check("after_abort_cycle", 256'(done_cyc), 256'(66));
    check("after_abort_digest", digest, ABC256);
    @(negedge clk);

    // 6: reset during r=40, then "abc" on the byte-swapped instance
    run_msg(1'b0, 16, 1'b0, -1, 41, -1, done_cyc, ngap);
    check("midrst_busy", 256'(busy), 256'(1'b0));
    check("midrst_w_ready", 256'(w_ready), 256'(1'b0));
    check("midrst_digest_valid", 256'(digest_valid), 256'(1'b0));
    check("midrst_digest", digest, IV256_DIG);
    check("midrst_digest_swapped", digest_sw, IV256_SW);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_msg(1'b0, 16, 1'b0, -1, -1, -1, done_cyc, ngap);
    check("swap_cycle", 256'(done_cyc), 256'(66));
    check("swap_word0", 256'(digest_sw[255:224]), 256'(32'hbf1678ba));
    check("swap_valid_pulse", 256'(digest_valid_sw), 256'(1'b1));
    @(negedge clk);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
